// File: rtl/grid_pkg.sv
// Shared definitions for the grid cursor slice: move directions, default
// grid geometry and the default-width coordinate type.
package grid_pkg;

    localparam int DEF_ROWS    = 3;
    localparam int DEF_COLS    = 3;
    localparam int DEF_COORD_W = 4;

    typedef logic [DEF_COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

endpackage

// File: rtl/grid_hist_stack.sv
// Bounded LIFO of committed coordinates. A circular buffer lets a push on a
// full stack silently overwrite the oldest entry without shifting storage.
module grid_hist_stack
    import grid_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DEF_COORD_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 top_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wptr, wnext, wprev;

    // wptr is the next write slot; the top of stack sits one slot behind it.
    assign wnext    = (wptr == LAST) ? '0 : wptr + PW'(1);
    assign wprev    = (wptr == '0) ? LAST : wptr - PW'(1);
    assign top_data = mem[wprev];

    // Push wins over pop; the caller never asserts both in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (push) begin
            mem[wptr] <= push_data;
            wptr      <= wnext;
            if (count != FULL) count <= count + CW'(1);
        end else if (pop && count != '0) begin
            wptr  <= wprev;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/grid_cursor.sv
// Player cursor on a ROWS x COLS grid: relative moves, direct load, undo from
// a committed-move history, and a valid/ready commit port downstream.
module grid_cursor
    import grid_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int COLS        = DEF_COLS,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int RESET_COORD = 0,
    parameter bit WRAP        = 1'b1,
    parameter int HIST_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              move_valid,
    input  logic [1:0]                        move_dir,
    input  logic                              load_en,
    input  logic [COORD_W-1:0]                load_coord,
    input  logic                              undo,
    input  logic                              commit_req,
    output logic                              commit_valid,
    output logic [COORD_W-1:0]                commit_coord,
    input  logic                              commit_ready,
    output logic [COORD_W-1:0]                coord_out,
    output logic [COORD_W-1:0]                row_out,
    output logic [COORD_W-1:0]                col_out,
    output logic [$clog2(HIST_DEPTH+1)-1:0]   hist_count,
    output logic                              err
);

    localparam int HCW = $clog2(HIST_DEPTH+1);
    localparam logic [COORD_W:0]   CELLS   = (COORD_W+1)'(ROWS*COLS);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(ROWS-1);
    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(COLS-1);
    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);
    localparam logic [COORD_W-1:0] RST_ROW = COORD_W'(RESET_COORD / COLS);
    localparam logic [COORD_W-1:0] RST_COL = COORD_W'(RESET_COORD % COLS);

    logic [COORD_W-1:0] row, col;
    logic [COORD_W-1:0] mv_row, mv_col, top;
    logic [HCW-1:0]     hcount;
    logic               mv_edge, hs, load_ok, undo_rej, pop;

    assign coord_out  = COORD_W'(row * COLS + col);
    assign row_out    = row;
    assign col_out    = col;
    assign hist_count = hcount;

    assign hs       = commit_valid & commit_ready;
    assign load_ok  = {1'b0, load_coord} < CELLS;
    // An undo that loses to a handshake or finds no history is rejected.
    assign undo_rej = undo & (hs | (hcount == '0));
    assign pop      = undo & ~undo_rej;

    // Candidate position for a relative move; at an edge either wrap or hold.
    always_comb begin
        mv_row  = row;
        mv_col  = col;
        mv_edge = 1'b0;
        case (dir_e'(move_dir))
            DIR_UP: begin
                if (row == '0) begin mv_edge = 1'b1; if (WRAP) mv_row = ROW_MAX; end
                else mv_row = row - ONE;
            end
            DIR_DOWN: begin
                if (row == ROW_MAX) begin mv_edge = 1'b1; if (WRAP) mv_row = '0; end
                else mv_row = row + ONE;
            end
            DIR_LEFT: begin
                if (col == '0) begin mv_edge = 1'b1; if (WRAP) mv_col = COL_MAX; end
                else mv_col = col - ONE;
            end
            default: begin
                if (col == COL_MAX) begin mv_edge = 1'b1; if (WRAP) mv_col = '0; end
                else mv_col = col + ONE;
            end
        endcase
    end

    // Cursor update with undo > load > move priority; err flags the winner's rejection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= RST_ROW;
            col <= RST_COL;
            err <= 1'b0;
        end else begin
            if (undo) begin
                if (pop) begin
                    row <= COORD_W'(top / COLS);
                    col <= COORD_W'(top % COLS);
                end
                err <= undo_rej;
            end else if (load_en) begin
                if (load_ok) begin
                    row <= COORD_W'(load_coord / COLS);
                    col <= COORD_W'(load_coord % COLS);
                end
                err <= ~load_ok;
            end else if (move_valid) begin
                row <= mv_row;
                col <= mv_col;
                err <= mv_edge & ~WRAP;
            end else begin
                err <= 1'b0;
            end
        end
    end

    // Commit port: capture the pre-update cursor, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_coord <= '0;
        end else if (commit_req && !commit_valid) begin
            commit_valid <= 1'b1;
            commit_coord <= coord_out;
        end else if (hs) begin
            commit_valid <= 1'b0;
        end
    end

    grid_hist_stack #(.DEPTH(HIST_DEPTH), .W(COORD_W)) u_hist (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (hs),
        .push_data (commit_coord),
        .pop       (pop),
        .top_data  (top),
        .count     (hcount)
    );

endmodule

// File: tb/tb_grid_cursor.sv
// Drives two 3x3 cursors (A: wrapping, reset at 4; B: saturating, reset at 2)
// with identical stimulus and compares both against a linear-coordinate model.
module tb_grid_cursor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_valid, load_en, undo, commit_req, commit_ready;
    logic [1:0] move_dir;
    logic [3:0] load_coord;

    logic [3:0] a_coord, a_row, a_col, a_cc, b_coord, b_row, b_col, b_cc;
    logic       a_cv, a_err, b_cv, b_err;
    logic [2:0] a_hc, b_hc;

    int n_cmp = 0;
    int n_bad = 0;

    // model state per instance: linear cursor, commit port, history array
    int mcur[2], mcv[2], mcc[2], mer[2], mhn[2];
    int mh[2][4];

    always #5 clk = ~clk;

    grid_cursor #(.ROWS(3), .COLS(3), .COORD_W(4), .RESET_COORD(4), .WRAP(1'b1), .HIST_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move_dir(move_dir),
        .load_en(load_en), .load_coord(load_coord), .undo(undo), .commit_req(commit_req),
        .commit_valid(a_cv), .commit_coord(a_cc), .commit_ready(commit_ready),
        .coord_out(a_coord), .row_out(a_row), .col_out(a_col), .hist_count(a_hc), .err(a_err)
    );

    grid_cursor #(.ROWS(3), .COLS(3), .COORD_W(4), .RESET_COORD(2), .WRAP(1'b0), .HIST_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move_dir(move_dir),
        .load_en(load_en), .load_coord(load_coord), .undo(undo), .commit_req(commit_req),
        .commit_valid(b_cv), .commit_coord(b_cc), .commit_ready(commit_ready),
        .coord_out(b_coord), .row_out(b_row), .col_out(b_col), .hist_count(b_hc), .err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === 32'(exp)) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mcur[0] = 4; mcur[1] = 2;
        for (int k = 0; k < 2; k++) begin
            mcv[k] = 0; mcc[k] = 0; mer[k] = 0; mhn[k] = 0;
        end
    endtask

    // One clock of the reference behaviour for instance k (k==0 wraps).
    task automatic mstep(input int k);
        int  old, r, c;
        bit  hs, e;
        hs  = (mcv[k] != 0) && commit_ready;
        old = mcur[k];
        r   = old / 3;
        c   = old % 3;
        e   = 1'b0;
        if (undo) begin
            if (hs || mhn[k] == 0) e = 1'b1;
            else begin
                mhn[k]--;
                mcur[k] = mh[k][mhn[k]];
            end
        end else if (load_en) begin
            if (load_coord < 9) mcur[k] = int'(load_coord);
            else e = 1'b1;
        end else if (move_valid) begin
            case (move_dir)
                2'd0: if (r > 0) r--; else if (k == 0) r = 2; else e = 1'b1;
                2'd1: if (r < 2) r++; else if (k == 0) r = 0; else e = 1'b1;
                2'd2: if (c > 0) c--; else if (k == 0) c = 2; else e = 1'b1;
                default: if (c < 2) c++; else if (k == 0) c = 0; else e = 1'b1;
            endcase
            mcur[k] = r * 3 + c;
        end
        if (hs) begin
            if (mhn[k] == 4) begin
                for (int i = 0; i < 3; i++) mh[k][i] = mh[k][i+1];
                mhn[k] = 3;
            end
            mh[k][mhn[k]] = mcc[k];
            mhn[k]++;
        end
        if (commit_req && mcv[k] == 0) begin
            mcc[k] = old;
            mcv[k] = 1;
        end else if (hs) begin
            mcv[k] = 0;
        end
        mer[k] = e;
    endtask

    task automatic chkall();
        chk("A.coord", a_coord, mcur[0]);
        chk("A.row",   a_row,   mcur[0] / 3);
        chk("A.col",   a_col,   mcur[0] % 3);
        chk("A.cvalid", a_cv,   mcv[0]);
        chk("A.ccoord", a_cc,   mcc[0]);
        chk("A.hcount", a_hc,   mhn[0]);
        chk("A.err",   a_err,   mer[0]);
        chk("B.coord", b_coord, mcur[1]);
        chk("B.row",   b_row,   mcur[1] / 3);
        chk("B.col",   b_col,   mcur[1] % 3);
        chk("B.cvalid", b_cv,   mcv[1]);
        chk("B.ccoord", b_cc,   mcc[1]);
        chk("B.hcount", b_hc,   mhn[1]);
        chk("B.err",   b_err,   mer[1]);
    endtask

    task automatic idle();
        move_valid = 0; move_dir = 0; load_en = 0; load_coord = 0;
        undo = 0; commit_req = 0; commit_ready = 0;
    endtask

    // Inputs are set while clk is low; check #1 after the edge.
    task automatic step();
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
        chkall();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chkall();
        rst_n = 1'b1;

        // wrap vs saturate
        idle(); load_en = 1; load_coord = 2; step();
        idle(); move_valid = 1; move_dir = 2'd3; step();
        idle(); move_valid = 1; move_dir = 2'd0; step();
        idle(); step();
        // out-of-range load beats move, then legal load
        idle(); load_en = 1; load_coord = 9; move_valid = 1; move_dir = 2'd1; step();
        idle(); load_en = 1; load_coord = 7; step();
        // held commit, move and re-request during wait, then accept
        idle(); load_en = 1; load_coord = 5; step();
        idle(); commit_req = 1; step();
        idle(); step();
        idle(); move_valid = 1; move_dir = 2'd1; commit_req = 1; step();
        idle(); commit_ready = 1; step();
        idle(); step();
        // five commits into a depth-4 history, then drain it
        for (int v = 1; v <= 5; v++) begin
            idle(); load_en = 1; load_coord = 4'(v); step();
            idle(); commit_req = 1; step();
            idle(); commit_ready = 1; step();
        end
        for (int u = 0; u < 5; u++) begin
            idle(); undo = 1; step();
        end
        // undo colliding with a handshake
        idle(); commit_req = 1; step();
        idle(); undo = 1; commit_ready = 1; step();
        // reset while a commit is pending
        idle(); commit_req = 1; step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("A.rst_cvalid", a_cv, 0);
        chk("B.rst_cvalid", b_cv, 0);
        chk("A.rst_hcount", a_hc, 0);
        chk("B.rst_hcount", b_hc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            undo         = ($urandom % 8) == 0;
            load_en      = ($urandom % 6) == 0;
            load_coord   = 4'($urandom % 12);
            move_valid   = ($urandom % 2) == 0;
            move_dir     = 2'($urandom % 4);
            commit_req   = ($urandom % 3) == 0;
            commit_ready = ($urandom % 2) == 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_cursor.md
Name: grid_cursor

Overview:
Parametrised successor to the single-coordinate grid register: holds the player's cursor position on an ROWS x COLS game grid. The cursor is updated by relative moves, a direct load, or an undo. Confirmed moves are handed downstream through a valid/ready commit port. Committed coordinates are kept in a bounded LIFO history so the last moves can be undone. Sits between the gesture/input decoder and the board-state/win-check logic.

Parameters:
ROWS, 3, grid rows (>=2)
COLS, 3, grid columns (>=2)
COORD_W, 4, width of linear coordinate; must satisfy 2**COORD_W >= ROWS*COLS
RESET_COORD, 0, linear cursor value after reset; must be < ROWS*COLS
WRAP, 1, 1 = moves wrap within row/column, 0 = moves saturate at edge
HIST_DEPTH, 4, committed-move history entries (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
move_valid  in  1  apply relative move this cycle
move_dir  in  2  0=up(row-1) 1=down(row+1) 2=left(col-1) 3=right(col+1)
load_en  in  1  direct cursor load
load_coord  in  COORD_W  linear coordinate to load (row*COLS+col)
undo  in  1  pop last committed coordinate into cursor
commit_req  in  1  request commit of current cursor
commit_valid  out  1  commit output holds a coordinate
commit_coord  out  COORD_W  committed linear coordinate
commit_ready  in  1  downstream accepts commit
coord_out  out  COORD_W  current cursor, linear
row_out  out  COORD_W  current cursor row
col_out  out  COORD_W  current cursor column
hist_count  out  clog2(HIST_DEPTH+1)  valid history entries
err  out  1  one-cycle pulse on rejected operation

Behaviour:
- Reset (async assert, sync-released use on next clk edge): cursor=RESET_COORD; commit_valid=0; commit_coord=0; history empty (hist_count=0); err=0.
- Cursor held internally as row/col registers; coord_out = row*COLS+col. All outputs registered except coord_out (combinational from row/col).
- Cursor update priority per cycle: undo > load_en > move_valid. Lower-priority requests in the same cycle are dropped silently.
- Move, WRAP=1: row/col wrap modulo ROWS/COLS. Example: col COLS-1 right -> 0; row 0 up -> ROWS-1.
- Move, WRAP=0: cursor unchanged at edge; err pulses.
- Load: if load_coord < ROWS*COLS, cursor = load_coord next cycle. Otherwise cursor is unchanged and err pulses.
- Commit handshake:
  - If commit_req and commit_valid=0: commit_coord = coord_out as it was before this cycle's cursor update; commit_valid=1 next cycle.
  - commit_valid stays 1 and commit_coord stays stable until the cycle where commit_valid && commit_ready; commit_valid=0 on the following cycle.
  - commit_req while commit_valid=1 is ignored (no err). This includes the handshake cycle itself: a new request needs commit_valid=0.
- History push on every handshake cycle (commit_valid && commit_ready): push commit_coord.
  - Full (hist_count=HIST_DEPTH): oldest entry discarded, hist_count stays HIST_DEPTH.
- Undo:
  - hist_count>0: cursor = top entry next cycle; entry popped; hist_count-1.
  - hist_count=0: no-op; err pulses.
  - Undo in a handshake cycle: undo ignored, push still happens, err pulses.
- err is the OR of all rejection causes, registered, high exactly one cycle per rejecting cycle.
- Reset mid-handshake: commit_valid drops immediately (async); the pending commit is lost and not pushed.

Decomposition:
- Shared package grid_pkg: direction encodings (DIR_UP/DOWN/LEFT/RIGHT), default ROWS/COLS, coordinate typedef.
- One sub-module: grid_hist_stack (circular-buffer LIFO with discard-oldest-on-full).
  - Ports: clk, rst_n, push, push_data, pop, top_data, count.
  - Parameters: DEPTH, W.

Test Plan:
- Reset with RESET_COORD=4 (3x3) -> coord_out=4, row_out=1, col_out=1, commit_valid=0, hist_count=0.
- WRAP=1, cursor 2, move right -> coord 0. Move up from 0 -> 6. WRAP=0 build, cursor 2, move right -> coord stays 2, err one-cycle pulse.
- load_coord=9 on 3x3 -> cursor unchanged, err=1. Same cycle as move_valid: move dropped. Next cycle load_coord=7 -> coord_out=7.
- Commit handshake:
  - Cursor 5: commit_req, commit_ready=0 for 3 cycles -> commit_valid=1, commit_coord=5 held.
  - Move and second commit_req during the wait -> commit_coord still 5.
  - commit_ready=1 -> commit_valid=0 next cycle, hist_count=1.
- HIST_DEPTH=4: commit 1,2,3,4,5 -> hist_count=4. Undo x4 -> cursor 5,4,3,2 in turn. Fifth undo -> err, cursor stays 2, hist_count=0.
- Undo asserted on a handshake cycle -> err, push performed, cursor unchanged. rst_n low while commit_valid=1 -> commit_valid=0 immediately, hist_count=0.
